// File: rtl/updown_count_sequencer_if.sv
// Job command channel for the up/down count sequencer.
// The requester drives the job fields; the sequencer returns ready.
interface updown_count_sequencer_if #(
    parameter int WIDTH   = 4,
    parameter int LOOP_W  = 4,
    parameter int PRESC_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [WIDTH-1:0]   cmd_start;
    logic [WIDTH-1:0]   cmd_end;
    logic [LOOP_W-1:0]  cmd_loops;
    logic [PRESC_W-1:0] cmd_presc;

    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_end,
        output cmd_loops,
        output cmd_presc,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_end,
        input  cmd_loops,
        input  cmd_presc,
        output cmd_ready
    );
endinterface

// File: rtl/updown_count_sequencer.sv
// Sweeps a counter from start to end, repeating for extra loops,
// with a per-value prescaler, pause and abort.
module updown_count_sequencer #(
    parameter int WIDTH   = 4,
    parameter int LOOP_W  = 4,
    parameter int PRESC_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_count_sequencer_if.slave cmd,
    input  logic                  pause,
    input  logic                  abort,
    output logic [WIDTH-1:0]      count,
    output logic                  up_down,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               up_down_q, up_down_d;
    logic [WIDTH-1:0]   start_q, start_d;
    logic [WIDTH-1:0]   end_q, end_d;
    logic [LOOP_W-1:0]  loops_q, loops_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;

    logic tick;
    logic at_end;

    assign tick   = (pcnt_q == presc_q);
    assign at_end = (count_q == end_q);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        up_down_d = up_down_q;
        start_d   = start_q;
        end_d     = end_q;
        loops_d   = loops_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    state_d   = RUN;
                    start_d   = cmd.cmd_start;
                    end_d     = cmd.cmd_end;
                    loops_d   = cmd.cmd_loops;
                    presc_d   = cmd.cmd_presc;
                    count_d   = cmd.cmd_start;
                    up_down_d = (cmd.cmd_end < cmd.cmd_start);
                    pcnt_d    = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    if (!tick) begin
                        pcnt_d = pcnt_q + PRESC_W'(1);
                    end else begin
                        pcnt_d = '0;
                        // the end value is compared before stepping, so no wrap
                        if (!at_end) begin
                            if (up_down_q)
                                count_d = count_q - WIDTH'(1);
                            else
                                count_d = count_q + WIDTH'(1);
                        end else if (loops_q != '0) begin
                            count_d = start_q;
                            loops_d = loops_q - LOOP_W'(1);
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            up_down_q <= 1'b0;
            start_q   <= '0;
            end_q     <= '0;
            loops_q   <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            up_down_q <= up_down_d;
            start_q   <= start_d;
            end_q     <= end_d;
            loops_q   <= loops_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign count         = count_q;
    assign up_down       = up_down_q;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Directed and randomized jobs checked against a sweep-list model.
// Each expected cycle value comes from an explicit list of held values.
module tb_updown_count_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pause;
    logic       abort;
    logic [3:0] count;
    logic       up_down;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    updown_count_sequencer_if #(.WIDTH(4), .LOOP_W(4), .PRESC_W(8)) cmd_if ();

    updown_count_sequencer #(.WIDTH(4), .LOOP_W(4), .PRESC_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd_if),
        .pause   (pause),
        .abort   (abort),
        .count   (count),
        .up_down (up_down),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'd0, cmd_if.cmd_ready}, 32'd1);
    endtask

    // Expected per-cycle count: each swept value repeated presc+1 times.
    task automatic build(input int s, input int e, input int loops,
                         input int presc, output int q[$]);
        int v;
        q = {};
        for (int l = 0; l <= loops; l++) begin
            v = s;
            forever begin
                for (int r = 0; r <= presc; r++) q.push_back(v);
                if (v == e) break;
                v = (e < s) ? v - 1 : v + 1;
            end
        end
    endtask

    task automatic run_job(input int s, input int e, input int loops,
                           input int presc, input int pause_at,
                           input int pause_len, input bit junk,
                           input int abort_at);
        int q[$];
        int last;
        build(s, e, loops, presc, q);
        last = q.size() - 1;
        wait_ready();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_start = 4'(s);
        cmd_if.cmd_end   = 4'(e);
        cmd_if.cmd_loops = 4'(loops);
        cmd_if.cmd_presc = 8'(presc);
        tick();
        cmd_if.cmd_valid = junk;
        cmd_if.cmd_start = 4'($urandom_range(15, 0));
        cmd_if.cmd_end   = 4'($urandom_range(15, 0));
        cmd_if.cmd_loops = 4'($urandom_range(15, 0));
        cmd_if.cmd_presc = 8'($urandom_range(3, 0));
        chk("up_down", {31'd0, up_down}, (e < s) ? 32'd1 : 32'd0);
        for (int i = 0; i <= last; i++) begin
            chk("count", {28'd0, count}, 32'(q[i]));
            chk("busy", {31'd0, busy}, 32'd1);
            chk("done_low", {31'd0, done}, 32'd0);
            if (i == last || i == abort_at) cmd_if.cmd_valid = 1'b0;
            if (i == abort_at) begin
                abort = 1'b1;
                pause = 1'b1;
                tick();
                abort = 1'b0;
                pause = 1'b0;
                chk("abort_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_count", {28'd0, count}, 32'(q[i]));
                return;
            end
            if (i == pause_at) begin
                pause = 1'b1;
                for (int p = 0; p < pause_len; p++) begin
                    tick();
                    chk("pause_count", {28'd0, count}, 32'(q[i]));
                    chk("pause_busy", {31'd0, busy}, 32'd1);
                end
                pause = 1'b0;
            end
            tick();
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_count", {28'd0, count}, 32'(e));
        chk("done_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        tick();
        chk("post_done", {31'd0, done}, 32'd0);
        chk("post_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        chk("post_count", {28'd0, count}, 32'(e));
    endtask

    initial begin
        int s;
        int e;
        int pr;
        reset            = 1'b0;
        pause            = 1'b0;
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_start = '0;
        cmd_if.cmd_end   = '0;
        cmd_if.cmd_loops = '0;
        cmd_if.cmd_presc = '0;
        #12;
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_updown", {31'd0, up_down}, 32'd0);
        chk("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        reset = 1'b1;
        tick();

        run_job(2, 5, 0, 0, -1, 0, 1'b0, -1);
        run_job(5, 2, 1, 0, -1, 0, 1'b1, -1);
        run_job(0, 15, 0, 2, -1, 0, 1'b0, -1);
        run_job(7, 7, 2, 1, -1, 0, 1'b0, -1);
        run_job(3, 12, 0, 1, 5, 4, 1'b0, -1);
        run_job(14, 4, 0, 0, -1, 0, 1'b0, 6);
        run_job(1, 9, 1, 1, 3, 2, 1'b0, 11);

        for (int j = 0; j < 10; j++) begin
            s  = int'($urandom_range(15, 0));
            e  = int'($urandom_range(15, 0));
            pr = int'($urandom_range(3, 0));
            run_job(s, e, int'($urandom_range(2, 0)), pr,
                    int'($urandom_range(6, 0)),
                    int'($urandom_range(4, 1)), j[0], -1);
        end

        wait_ready();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_start = 4'd3;
        cmd_if.cmd_end   = 4'd12;
        cmd_if.cmd_loops = 4'd0;
        cmd_if.cmd_presc = 8'd1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        repeat (5) tick();
        chk("pre_rst_count", {28'd0, count}, 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", {28'd0, count}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        chk("arst_done", {31'd0, done}, 32'd0);
        #2;
        reset = 1'b1;
        tick();
        chk("arst_idle", {31'd0, busy}, 32'd0);

        run_job(9, 6, 0, 0, -1, 0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
